// File: rtl/bch_pkg.sv
// Shared BCH decoder constants: field size, correction capability and field-element type.
package bch_pkg;
    localparam int unsigned M     = 6;
    localparam int unsigned T     = 4;
    localparam int unsigned NSYN  = 2 * T;
    localparam int unsigned SYN_W = M * (NSYN + 1);
    localparam int unsigned LAM_W = M * (T + 1);

    typedef logic [M-1:0] gf_t;

    // x^6 + x + 1 with the x^M term dropped
    localparam gf_t POLY = 6'b000011;
endpackage

// File: rtl/gf_mul_comb.sv
// Combinational GF(2^M) shift-and-add multiplier, reduced modulo POLY.
module gf_mul_comb
    import bch_pkg::*;
(
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    gf_t acc;
    gf_t sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[M-1] ? ((sh << 1) ^ POLY) : (sh << 1);
        end
        p = acc;
    end
endmodule

// File: rtl/bch_key_equation_solver.sv
// Serial inversionless Berlekamp-Massey: syndromes in, error-locator polynomial,
// its degree and an uncorrectable flag out for the Chien search.
module bch_key_equation_solver
    import bch_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [SYN_W-1:0] syndrome,
    output logic             finish_flag,
    output logic [LAM_W-1:0] lambda,
    output logic [2:0]       degree,
    output logic             uncorrectable
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_DISC   = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_CHECK  = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    localparam logic [2:0] J_LAST = 3'(T);
    localparam logic [3:0] R_LAST = 4'(NSYN - 1);
    localparam logic [3:0] L_MAX  = 4'(T);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       start_d;
    logic       done;
    logic       swap;
    logic       ovf;
    gf_t        syn [NSYN];
    gf_t        lam [T+1];
    gf_t        bb  [T+1];
    gf_t        delta;
    gf_t        gamma;
    logic [3:0] len;
    logic [3:0] r;
    logic [2:0] j;

    logic       start_edge;
    logic       accept;
    logic       syn_zero;
    logic [2:0] dl;
    gf_t        s_term;
    gf_t        b_prev;
    gf_t        mul0_b;
    gf_t        prod0;
    gf_t        prod1;
    logic       syn_unused;

    assign syn_unused  = ^syndrome[SYN_W-1 -: M];
    assign start_edge  = start & ~start_d;
    assign accept      = (state == S_IDLE) & start_edge;
    assign finish_flag = (state == S_FINISH) | ((state == S_IDLE) & done & ~start_edge);

    // S(r+1-j) lives at syn[r-j]; indices below S1 read as zero
    assign s_term = (r >= 4'(j)) ? syn[3'(r - 4'(j))] : '0;
    assign b_prev = (j == 3'd0) ? '0 : bb[j - 3'd1];
    assign mul0_b = (state == S_DISC) ? s_term : gamma;

    // Instance 0: Lam_j*S during DISC, gamma*Lam_j during UPDATE
    gf_mul_comb u_mul0 (.a(lam[j]), .b(mul0_b), .p(prod0));
    gf_mul_comb u_mul1 (.a(delta),  .b(b_prev), .p(prod1));

    always_comb begin
        syn_zero = 1'b1;
        for (int i = 0; i < int'(NSYN); i++) begin
            if (syn[i] != '0) syn_zero = 1'b0;
        end
        dl = 3'd0;
        for (int i = 0; i <= int'(T); i++) begin
            if (lam[i] != '0) dl = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_INIT;
            S_INIT:   state_nxt = syn_zero ? S_CHECK : S_DISC;
            S_DISC:   if (j == J_LAST) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = S_UPDATE;
            S_UPDATE: if (j == 3'd0) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = (r == R_LAST) ? S_CHECK : S_DISC;
            S_CHECK:  state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_d       <= 1'b0;
            done          <= 1'b0;
            swap          <= 1'b0;
            ovf           <= 1'b0;
            delta         <= '0;
            gamma         <= '0;
            len           <= '0;
            r             <= '0;
            j             <= '0;
            lambda        <= '0;
            degree        <= '0;
            uncorrectable <= 1'b0;
            for (int i = 0; i < int'(NSYN); i++) syn[i] <= '0;
            for (int i = 0; i <= int'(T); i++) begin
                lam[i] <= '0;
                bb[i]  <= '0;
            end
        end else begin
            start_d <= start;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        done <= 1'b0;
                        for (int i = 0; i < int'(NSYN); i++) syn[i] <= syndrome[M*(NSYN-i)-1 -: M];
                    end
                end
                S_INIT: begin
                    for (int i = 0; i <= int'(T); i++) begin
                        lam[i] <= (i == 0) ? gf_t'(1) : gf_t'(0);
                        bb[i]  <= (i == 0) ? gf_t'(1) : gf_t'(0);
                    end
                    gamma <= gf_t'(1);
                    len   <= '0;
                    r     <= '0;
                    j     <= '0;
                    ovf   <= 1'b0;
                end
                S_DISC: begin
                    delta <= (j == 3'd0) ? prod0 : (delta ^ prod0);
                    if (j != J_LAST) j <= j + 3'd1;
                end
                S_DECIDE: swap <= (delta != '0) && ({len, 1'b0} <= {1'b0, r});
                // Descending j keeps B(j-1) and Lam_j at their pre-update values
                S_UPDATE: begin
                    lam[j] <= prod0 ^ prod1;
                    bb[j]  <= swap ? lam[j] : b_prev;
                    if ((j == J_LAST) && (delta != '0) && (bb[j] != '0)) ovf <= 1'b1;
                    if (j != 3'd0) j <= j - 3'd1;
                end
                S_NEXT: begin
                    r <= r + 4'd1;
                    j <= '0;
                    if (swap) begin
                        gamma <= delta;
                        len   <= r + 4'd1 - len;
                    end
                end
                S_CHECK: begin
                    for (int i = 0; i <= int'(T); i++) lambda[M*i +: M] <= lam[i];
                    degree        <= (len > 4'd7) ? 3'd7 : len[2:0];
                    uncorrectable <= ovf | (len > L_MAX) | ({1'b0, dl} != len);
                end
                S_FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bch_key_equation_solver.sv
// Directed bench for the iBM key-equation solver; syndromes and root checks come
// from a log/antilog GF(2^6) model.
module tb_bch_key_equation_solver;
    import bch_pkg::*;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             start = 1'b0;
    logic [SYN_W-1:0] syndrome = '0;
    logic             finish_flag;
    logic [LAM_W-1:0] lambda;
    logic [2:0]       degree;
    logic             uncorrectable;

    int  n_checks = 0;
    int  n_fail   = 0;
    gf_t apow [63];
    int  alog [64];

    always #5 clk = ~clk;

    bch_key_equation_solver dut (
        .clk           (clk),
        .resetN        (resetN),
        .start         (start),
        .syndrome      (syndrome),
        .finish_flag   (finish_flag),
        .lambda        (lambda),
        .degree        (degree),
        .uncorrectable (uncorrectable)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic gf_t gmul(input gf_t a, input gf_t b);
        if (a == '0 || b == '0) return '0;
        return apow[(alog[a] + alog[b]) % 63];
    endfunction

    // S_i = sum over error positions of alpha^(i*p); junk goes into the ignored top field
    function automatic logic [SYN_W-1:0] make_syn(input int pos[$], input gf_t junk);
        logic [SYN_W-1:0] v;
        gf_t s;
        v = '0;
        v[SYN_W-1 -: M] = junk;
        for (int i = 1; i <= int'(NSYN); i++) begin
            s = '0;
            foreach (pos[k]) s = s ^ apow[(i * pos[k]) % 63];
            v[M*(int'(NSYN)-i) +: M] = s;
        end
        return v;
    endfunction

    function automatic logic [62:0] pos_mask(input int pos[$]);
        logic [62:0] m;
        m = '0;
        foreach (pos[k]) m[pos[k]] = 1'b1;
        return m;
    endfunction

    // Bit p set when Lambda(alpha^-p) == 0
    function automatic logic [62:0] root_mask(input logic [LAM_W-1:0] lv);
        logic [62:0] m;
        gf_t acc;
        gf_t c;
        m = '0;
        for (int p = 0; p < 63; p++) begin
            acc = '0;
            for (int jj = 0; jj <= int'(T); jj++) begin
                c = lv[M*jj +: M];
                acc = acc ^ gmul(c, apow[(63 - (p * jj) % 63) % 63]);
            end
            m[p] = (acc == '0);
        end
        return m;
    endfunction

    // Launch one run; cyc counts cycles from the accept cycle to the first cycle with finish_flag high
    task automatic run(input logic [SYN_W-1:0] sv, input bit hold, output int cyc);
        @(negedge clk);
        start    = 1'b0;
        syndrome = sv;
        repeat (2) @(negedge clk);
        start = 1'b1;
        #1 check_val("flag_drop_on_accept", 64'(finish_flag), 64'd0);
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            syndrome = ~sv;
            if (finish_flag) break;
        end
    endtask

    task automatic check_decode(input string tag, input int pos[$], input gf_t junk);
        int cyc;
        run(make_syn(pos, junk), 1'b0, cyc);
        check_val({tag, "_latency"}, 64'(cyc), 64'd99);
        check_val({tag, "_roots"}, 64'(root_mask(lambda)), 64'(pos_mask(pos)));
        check_val({tag, "_degree"}, 64'(degree), 64'(pos.size()));
        check_val({tag, "_unc"}, 64'(uncorrectable), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int               cyc;
        int               drops;
        int               p [$];
        logic [SYN_W-1:0] sv;
        logic             det;
        gf_t              l0;
        gf_t              l1;

        apow[0] = 6'd1;
        for (int k = 1; k < 63; k++)
            apow[k] = apow[k-1][M-1] ? ((apow[k-1] << 1) ^ POLY) : (apow[k-1] << 1);
        alog[0] = 0;
        for (int k = 0; k < 63; k++) alog[apow[k]] = k;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_finish", 64'(finish_flag), 64'd0);
        check_val("rst_lambda", 64'(lambda), 64'd0);
        check_val("rst_degree", 64'(degree), 64'd0);
        check_val("rst_unc", 64'(uncorrectable), 64'd0);
        resetN = 1'b1;

        // Zero-syndrome fast path
        run('0, 1'b0, cyc);
        check_val("t1_latency", 64'(cyc), 64'd3);
        check_val("t1_lambda", 64'(lambda), 64'h1);
        check_val("t1_degree", 64'(degree), 64'd0);
        check_val("t1_unc", 64'(uncorrectable), 64'd0);
        repeat (4) @(negedge clk);
        check_val("t1_flag_held", 64'(finish_flag), 64'd1);
        check_val("t1_lambda_held", 64'(lambda), 64'h1);

        // All syndromes one: error at bit 0
        sv = '0;
        for (int i = 1; i <= int'(NSYN); i++) sv[M*(int'(NSYN)-i) +: M] = 6'd1;
        run(sv, 1'b0, cyc);
        check_val("t2_latency", 64'(cyc), 64'd99);
        check_val("t2_lambda", 64'(lambda), 64'h041);
        check_val("t2_degree", 64'(degree), 64'd1);
        check_val("t2_unc", 64'(uncorrectable), 64'd0);

        // S_i = alpha^i: Lambda proportional to 1 + alpha*x
        p = {1};
        run(make_syn(p, 6'd0), 1'b0, cyc);
        sv = '0;
        sv[LAM_W-1:0] = lambda;
        l0 = sv[5:0];
        l1 = sv[11:6];
        check_val("t3_lam0_nonzero", 64'(l0 != '0), 64'd1);
        check_val("t3_lam1_ratio", 64'(l1), 64'(gmul(6'd2, l0)));
        check_val("t3_upper_zero", 64'(sv[29:12]), 64'd0);
        check_val("t3_degree", 64'(degree), 64'd1);
        check_val("t3_unc", 64'(uncorrectable), 64'd0);

        // 2/3/4 errors, junk in the ignored syndrome field
        p = {3, 17};          check_decode("t4a", p, 6'h2A);
        p = {0, 40, 62};      check_decode("t4b", p, 6'h3F);
        p = {5, 21, 33, 58};  check_decode("t4c", p, 6'h00);
        p = {1, 2, 61, 62};   check_decode("t4d", p, 6'h15);

        // Beyond capability: must be flagged or produce a wrong locator
        p = {4, 9, 30, 44, 60};
        run(make_syn(p, 6'd0), 1'b0, cyc);
        det = uncorrectable | (root_mask(lambda) != pos_mask(p));
        check_val("t5_five_err_detected", 64'(det), 64'd1);
        p = {6, 13, 27, 38, 49, 55};
        run(make_syn(p, 6'd0), 1'b0, cyc);
        det = uncorrectable | (root_mask(lambda) != pos_mask(p));
        check_val("t5_six_err_detected", 64'(det), 64'd1);

        // Start held high for ~300 cycles launches exactly one run
        p = {7, 25, 50};
        run(make_syn(p, 6'd0), 1'b1, cyc);
        check_val("t5_hold_latency", 64'(cyc), 64'd99);
        check_val("t5_hold_roots", 64'(root_mask(lambda)), 64'(pos_mask(p)));
        drops = 0;
        repeat (200) begin
            @(negedge clk);
            if (!finish_flag) drops++;
        end
        check_val("t5_hold_single_run", 64'(drops), 64'd0);
        start = 1'b0;

        // Reset in mid-run, then a fresh run
        p = {11, 12};
        @(negedge clk);
        syndrome = make_syn(p, 6'd0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (40) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetN = 1'b0;
        #1;
        check_val("t6_rst_finish", 64'(finish_flag), 64'd0);
        check_val("t6_rst_lambda", 64'(lambda), 64'd0);
        check_val("t6_rst_degree", 64'(degree), 64'd0);
        check_val("t6_rst_unc", 64'(uncorrectable), 64'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t6_idle_flag", 64'(finish_flag), 64'd0);
        check_val("t6_idle_lambda", 64'(lambda), 64'd0);
        check_decode("t6_rerun", p, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
